// File: rtl/operand_accumulator_pkg.sv
// Shared definitions for the operand accumulator: datapath width, FSM
// state encodings and the saturation constant.
package operand_accumulator_pkg;

    localparam int ACC_W = 5;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } acc_state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    // Value loaded into the accumulator on an accept: the wrapped sum, or the
    // all-ones ceiling when saturation is requested and the adder carried out.
    function automatic logic [ACC_W-1:0] acc_load(
        input logic [ACC_W-1:0] sum,
        input logic             carry,
        input logic             saturate
    );
        if (saturate && carry) begin
            return ACC_MAX;
        end
        return sum;
    endfunction

endpackage

// File: rtl/operand_accumulator_adder.sv
// fiveBitFullAdder: the ripple-carry adder that forms the accumulator's only
// datapath element. One full-adder cell per bit, carry rippling LSB to MSB.
module fiveBitFullAdder
    import operand_accumulator_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             ci,
    output logic [ACC_W-1:0] s,
    output logic             co
);

    logic [ACC_W:0] carry;

    assign carry[0] = ci;

    // Ripple chain: each cell produces its sum bit and the carry for the next.
    generate
        for (genvar gi = 0; gi < ACC_W; gi++) begin : g_bit
            assign s[gi]        = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign co = carry[ACC_W];

endmodule

// File: rtl/operand_accumulator.sv
// operand_accumulator: sums N_OPS unsigned operands received over a
// valid/ready handshake and presents the batch sum plus a sticky carry-out
// flag over an output valid/ready handshake.
// Optional build macro ACC_SATURATE_EN: a carry-out clamps the accumulator to
// all-ones instead of wrapping modulo 2**ACC_W.
module operand_accumulator
    import operand_accumulator_pkg::*;
#(
    parameter int N_OPS = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    // Reject configurations where the counter cannot reach N_OPS-1.
    generate
        if (N_OPS < 1 || N_OPS > (2**CNT_W) - 1) begin : g_bad_cfg
            $error("operand_accumulator: N_OPS must be 1..2**CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS - 1);

`ifdef ACC_SATURATE_EN
    localparam logic SATURATE = 1'b1;
`else
    localparam logic SATURATE = 1'b0;
`endif

    acc_state_t       state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic             ovf_reg, ovf_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             out_valid_reg, out_valid_next;

    logic [ACC_W-1:0] add_sum;
    logic             add_co;
    logic             accept;

    // Single adder instance; carry-in is unused because every accept starts
    // from the accumulator value alone.
    fiveBitFullAdder u_adder (
        .a  (acc_reg),
        .b  (in_data),
        .ci (1'b0),
        .s  (add_sum),
        .co (add_co)
    );

    assign in_ready  = (state_reg == ST_ACC) && !clr;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign out_sum   = acc_reg;
    assign out_ovf   = ovf_reg;

    // Next-state logic: soft clear wins over everything except reset.
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        ovf_next       = ovf_reg;
        cnt_next       = cnt_reg;
        out_valid_next = out_valid_reg;

        if (clr) begin
            state_next     = ST_ACC;
            acc_next       = '0;
            ovf_next       = 1'b0;
            cnt_next       = '0;
            out_valid_next = 1'b0;
        end else begin
            case (state_reg)
                ST_ACC: begin
                    if (accept) begin
                        acc_next = acc_load(add_sum, add_co, SATURATE);
                        ovf_next = ovf_reg | add_co;
                        if (cnt_reg == LAST_CNT) begin
                            cnt_next       = '0;
                            state_next     = ST_DONE;
                            out_valid_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_valid_reg && out_ready) begin
                        state_next     = ST_ACC;
                        out_valid_next = 1'b0;
                        acc_next       = '0;
                        ovf_next       = 1'b0;
                    end
                end
                default: begin
                    state_next = ST_ACC;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_ACC;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            ovf_reg       <= ovf_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
        end
    end

endmodule

// File: tb/tb_operand_accumulator.sv
// Directed testbench for operand_accumulator with N_OPS=4. Inputs change 1ns
// after each rising edge and outputs are checked at that same point.
module tb_operand_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_sum;
    logic       out_ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    operand_accumulator #(.N_OPS(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand for exactly one cycle (in_valid stays as left).
    task automatic push(input logic [4:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
    endtask

    // Feed four operands back-to-back, then check the result one cycle later.
    task automatic batch4(input string tag, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] c, input logic [4:0] d,
                          input logic [4:0] exp_sum, input logic exp_ovf);
        push(a);
        push(b);
        push(c);
        check_val({tag, ".pre_valid"}, out_valid, 0);
        push(d);
        in_valid = 1'b0;
        check_val({tag, ".valid"}, out_valid, 1);
        check_val({tag, ".sum"}, out_sum, exp_sum);
        check_val({tag, ".ovf"}, out_ovf, exp_ovf);
        check_val({tag, ".in_ready"}, in_ready, 0);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({tag, ".drained"}, out_valid, 0);
        check_val({tag, ".acc_cleared"}, out_sum, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check_val("rst.in_ready", in_ready, 1);
        check_val("rst.out_valid", out_valid, 0);
        check_val("rst.out_sum", out_sum, 0);
        check_val("rst.out_ovf", out_ovf, 0);

        // 1. 3+5+7+9 = 24, no carry
        batch4("t1", 5'd3, 5'd5, 5'd7, 5'd9, 5'd24, 1'b0);
        consume("t1");

        // 2. 20+15 carries (35 mod 32 = 3), +1 +0 -> 4; saturating build clamps to 31
`ifdef ACC_SATURATE_EN
        batch4("t2", 5'd20, 5'd15, 5'd1, 5'd0, 5'd31, 1'b1);
`else
        batch4("t2", 5'd20, 5'd15, 5'd1, 5'd0, 5'd4, 1'b1);
`endif
        consume("t2");

        // 3. Backpressure: result held while out_ready=0 and input ignored
        batch4("t3a", 5'd3, 5'd5, 5'd7, 5'd9, 5'd24, 1'b0);
        in_valid = 1'b1;
        in_data  = 5'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val($sformatf("t3.hold%0d.in_ready", i), in_ready, 0);
            check_val($sformatf("t3.hold%0d.valid", i), out_valid, 1);
            check_val($sformatf("t3.hold%0d.sum", i), out_sum, 24);
        end
        in_valid = 1'b0;
        consume("t3");
        batch4("t3b", 5'd1, 5'd1, 5'd1, 5'd1, 5'd4, 1'b0);
        consume("t3b");

        // 4. Soft clear mid-batch discards the partial sum and the clr-cycle operand
        push(5'd10);
        push(5'd10);
        clr     = 1'b1;
        in_data = 5'd10;
        #1;
        check_val("t4.clr_in_ready", in_ready, 0);
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        check_val("t4.after_clr_sum", out_sum, 0);
        batch4("t4", 5'd1, 5'd1, 5'd1, 5'd1, 5'd4, 1'b0);
        consume("t4");

        // 5. Reset mid-batch
        push(5'd6);
        push(5'd6);
        push(5'd6);
        in_valid = 1'b0;
        check_val("t5.partial_sum", out_sum, 18);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_val("t5.rst_valid", out_valid, 0);
        check_val("t5.rst_sum", out_sum, 0);
        check_val("t5.rst_in_ready", in_ready, 1);
        batch4("t5", 5'd2, 5'd2, 5'd2, 5'd2, 5'd8, 1'b0);
        consume("t5");

        // 6. Bubbles between operands do not count
        push(5'd1);
        in_valid = 1'b0; tick();
        push(5'd2);
        in_valid = 1'b0; tick();
        push(5'd3);
        in_valid = 1'b0; tick();
        check_val("t6.pre_valid", out_valid, 0);
        check_val("t6.partial_sum", out_sum, 6);
        push(5'd4);
        in_valid = 1'b0;
        check_val("t6.valid", out_valid, 1);
        check_val("t6.sum", out_sum, 10);
        check_val("t6.ovf", out_ovf, 0);
        consume("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
